shader_prog_loader: RTL



---
 rtl/simt_pkg.sv | 53 +++++
 rtl/shader_prog_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/simt_pkg.sv
// Shared SIMT definitions: opcodes, instruction field layout, loader FSM states.
package simt_pkg;

  localparam logic [7:0] OP_FADD = 8'h01;
  localparam logic [7:0] OP_FMUL = 8'h02;
  localparam logic [7:0] OP_LDR  = 8'h10;
  localparam logic [7:0] OP_STR  = 8'h11;
  localparam logic [7:0] OP_EXIT = 8'h3F;

  // Predicate guard used by every generated word.
  localparam logic [3:0] PG_ALL = 4'h7;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  rd;
    logic [7:0]  rs1;
    logic [7:0]  rs2;
    logic [3:0]  pg;
    logic [7:0]  rs3;
    logic [19:0] imm;
  } inst_t;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_PRO,
    LD_COPY,
    LD_EPI,
    LD_FILL,
    LD_LAUNCH,
    LD_ERR_DRAIN
  } loader_state_e;

  function automatic logic [63:0] encode_inst(
    input logic [7:0]  op,
    input logic [7:0]  rd,
    input logic [7:0]  rs1,
    input logic [7:0]  rs2,
    input logic [7:0]  rs3,
    input logic [3:0]  pg,
    input logic [19:0] imm
  );
    inst_t w;
    w.op  = op;
    w.rd  = rd;
    w.rs1 = rs1;
    w.rs2 = rs2;
    w.pg  = pg;
    w.rs3 = rs3;
    w.imm = imm;
    return w;
  endfunction

endpackage

// File: rtl/shader_prog_loader.sv
// Wraps a raw shader stream with an input-load prologue and an output-store
// epilogue before every EXIT, writes it into SM program memory, pads the rest
// with EXIT and launches warp 0.
module shader_prog_loader
  import simt_pkg::*;
#(
  parameter int PROG_DEPTH   = 256,
  parameter int NUM_IN       = 2,
  parameter int IN_BASE_REG  = 2,
  parameter int IN_ADDR      = 0,
  parameter int NUM_OUT      = 4,
  parameter int OUT_BASE_REG = 4,
  parameter int OUT_ADDR     = 100
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [63:0]                   s_data,
  input  logic                          s_last,
  output logic                          prog_we,
  output logic [$clog2(PROG_DEPTH)-1:0] prog_waddr,
  output logic [63:0]                   prog_wdata,
  output logic                          launch,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [$clog2(PROG_DEPTH):0]   inst_count
);

  localparam int AW = $clog2(PROG_DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = 16;

  localparam logic [PW-1:0] PC_END   = PW'(PROG_DEPTH);
  localparam logic [IW-1:0] IN_LAST  = IW'(NUM_IN - 1);
  localparam logic [IW-1:0] OUT_EXIT = IW'(NUM_OUT);

  loader_state_e state;
  logic [PW-1:0] pc;
  logic [IW-1:0] idx;
  logic          last_flag;

  logic [7:0]  in_op;
  logic        pc_full;
  logic [63:0] exit_word;
  logic [63:0] pro_word;
  logic [63:0] epi_word;

  // Generated words and decode of the incoming beat.
  always_comb begin
    in_op     = s_data[63:56];
    pc_full   = (pc == PC_END);
    exit_word = encode_inst(OP_EXIT, '0, '0, '0, '0, PG_ALL, '0);
    pro_word  = encode_inst(OP_LDR, 8'(IN_BASE_REG + int'(idx)), '0, '0, '0,
                            PG_ALL, 20'(IN_ADDR + 4 * int'(idx)));
    if (idx == OUT_EXIT) begin
      epi_word = exit_word;
    end else begin
      epi_word = encode_inst(OP_STR, '0, '0, 8'(OUT_BASE_REG + int'(idx)), '0,
                             PG_ALL, 20'(OUT_ADDR + 4 * int'(idx)));
    end
  end

  // Loader FSM: every write and status output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LD_IDLE;
      pc         <= '0;
      idx        <= '0;
      last_flag  <= 1'b0;
      s_ready    <= 1'b0;
      prog_we    <= 1'b0;
      prog_waddr <= '0;
      prog_wdata <= '0;
      launch     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      inst_count <= '0;
    end else begin
      prog_we <= 1'b0;
      launch  <= 1'b0;
      done    <= 1'b0;

      case (state)
        LD_IDLE: begin
          if (start) begin
            pc         <= '0;
            idx        <= '0;
            last_flag  <= 1'b0;
            overflow   <= 1'b0;
            inst_count <= '0;
            busy       <= 1'b1;
            if (NUM_IN == 0) begin
              state   <= LD_COPY;
              s_ready <= 1'b1;
            end else begin
              state <= LD_PRO;
            end
          end
        end

        LD_PRO: begin
          if (pc_full) begin
            overflow <= 1'b1;
            state    <= LD_ERR_DRAIN;
            s_ready  <= 1'b1;
          end else begin
            prog_we    <= 1'b1;
            prog_waddr <= pc[AW-1:0];
            prog_wdata <= pro_word;
            pc         <= pc + 1'b1;
            inst_count <= inst_count + 1'b1;
            if (idx == IN_LAST) begin
              idx     <= '0;
              state   <= LD_COPY;
              s_ready <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        LD_COPY: begin
          if (s_valid && s_ready) begin
            if (in_op == OP_EXIT) begin
              // The EXIT itself is re-emitted at the end of the epilogue.
              last_flag <= s_last;
              idx       <= '0;
              state     <= LD_EPI;
              s_ready   <= 1'b0;
            end else if (pc_full) begin
              overflow <= 1'b1;
              if (s_last) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                s_ready <= 1'b0;
                state   <= LD_IDLE;
              end else begin
                state <= LD_ERR_DRAIN;
              end
            end else begin
              prog_we    <= 1'b1;
              prog_waddr <= pc[AW-1:0];
              prog_wdata <= s_data;
              pc         <= pc + 1'b1;
              inst_count <= inst_count + 1'b1;
              if (s_last) begin
                state   <= LD_FILL;
                s_ready <= 1'b0;
              end
            end
          end
        end

        LD_EPI: begin
          if (pc_full) begin
            overflow <= 1'b1;
            // With the last beat already consumed there is nothing to drain.
            if (last_flag) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= LD_IDLE;
            end else begin
              state   <= LD_ERR_DRAIN;
              s_ready <= 1'b1;
            end
          end else begin
            prog_we    <= 1'b1;
            prog_waddr <= pc[AW-1:0];
            prog_wdata <= epi_word;
            pc         <= pc + 1'b1;
            inst_count <= inst_count + 1'b1;
            if (idx == OUT_EXIT) begin
              idx <= '0;
              if (last_flag) begin
                state <= LD_FILL;
              end else begin
                state   <= LD_COPY;
                s_ready <= 1'b1;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        LD_FILL: begin
          // Launch only once pc has passed the last slot, so the final write
          // has landed before warp 0 is released.
          if (pc_full) begin
            launch <= 1'b1;
            done   <= 1'b1;
            state  <= LD_LAUNCH;
          end else begin
            prog_we    <= 1'b1;
            prog_waddr <= pc[AW-1:0];
            prog_wdata <= exit_word;
            pc         <= pc + 1'b1;
          end
        end

        LD_LAUNCH: begin
          busy  <= 1'b0;
          state <= LD_IDLE;
        end

        LD_ERR_DRAIN: begin
          if (s_valid && s_ready && s_last) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            s_ready <= 1'b0;
            state   <= LD_IDLE;
          end
        end

        default: begin
          busy    <= 1'b0;
          s_ready <= 1'b0;
          state   <= LD_IDLE;
        end
      endcase
    end
  end

endmodule
